seq_mag_cmp: RTL
================

SEQ_MAG_CMP -- requirements
Module: seq_mag_cmp

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; SHALL be a multiple of DIGIT and at least DIGIT.
REQ-002 Parameter DIGIT, default 2, bits compared per cycle; SHALL be at least 1.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  request a comparison of A and B.
REQ-006 A  input  WIDTH  unsigned operand A; sampled only on accepted start.
REQ-007 B  input  WIDTH  unsigned operand B; sampled only on accepted start.
REQ-008 busy  output  1  comparison in progress.
REQ-009 done  output  1  single-cycle pulse: result valid.
REQ-010 GT  output  1  A > B.
REQ-011 EQ  output  1  A == B.
REQ-012 LT  output  1  A < B.

Function
REQ-013 FSM states IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE after last digit; DONE->RUN on start, else DONE->IDLE.
REQ-014 start SHALL be accepted only in IDLE or DONE; start in RUN SHALL be ignored, operands not resampled.
REQ-015 On accept, A and B SHALL be captured into internal shift registers and a digit counter loaded with WIDTH/DIGIT.
REQ-016 In RUN, each cycle SHALL compare the most-significant unprocessed DIGIT bits of A and B, then shift both left by DIGIT.
REQ-017 First differing digit (MSB first) SHALL decide GT or LT; later digits SHALL NOT alter a decided result.
REQ-018 If no digit differs, result SHALL be EQ.
REQ-019 busy SHALL be 1 exactly in RUN.
REQ-020 done SHALL be 1 exactly in DONE, one cycle per comparison.
REQ-021 Latency: start accepted at edge k -> done high in cycle k + WIDTH/DIGIT (macro off).
REQ-022 GT/EQ/LT SHALL update only on entry to DONE and hold stable until the next DONE; exactly one SHALL be 1 after first completion.
REQ-023 Back-to-back: start during DONE SHALL begin a new comparison with no idle cycle; previous result held until the new DONE.

Reset
REQ-024 rst SHALL force IDLE, busy=0, done=0, GT=0, EQ=0, LT=0, clear counter and shift registers, asynchronously.
REQ-025 rst during RUN SHALL abort the comparison; no done pulse SHALL follow.
REQ-026 First comparison after rst SHALL behave identically to any other.

Configuration
REQ-027 Macro SEQ_MAG_CMP_EARLY_EXIT_EN defined: RUN SHALL transition to DONE on the edge after the first differing digit; latency = index of first differing digit (1-based), EQ still WIDTH/DIGIT.
REQ-028 Macro undefined: latency SHALL always be WIDTH/DIGIT regardless of data.

Structure
REQ-029 Shared package cmp_pkg SHALL hold FSM state encodings and result encoding constants (RES_GT, RES_EQ, RES_LT).
REQ-030 One sub-module mag_cmp_digit (combinational, DIGIT-bit unsigned compare, outputs gt/eq) SHALL be instantiated once.

Verification (WIDTH=8, DIGIT=2)
REQ-031 A=0xA5, B=0xA5, start pulse -> done 4 cycles later, EQ=1, GT=0, LT=0.
REQ-032 A=0x80, B=0x7F -> GT=1; done after 4 cycles (macro off), after 1 cycle (macro on).
REQ-033 A=0x01, B=0x02 -> LT=1, done after 4 cycles in both modes.
REQ-034 start with A=0x10,B=0x20, then start with A=0xFF,B=0x00 during RUN -> second ignored, LT=1 reported once.
REQ-035 Start during DONE with A=0x03,B=0x02 -> busy next cycle, GT=1 after 4 cycles; prior result held meanwhile.
REQ-036 rst asserted mid-RUN (cycle 2) -> all outputs 0 immediately, no done pulse; new start afterwards completes normally.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared encodings for the digit-serial magnitude comparator: FSM states and
// one-hot result vectors ordered {GT, EQ, LT}.
package cmp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef logic [2:0] res_t;

   localparam res_t RES_GT = 3'b100;
   localparam res_t RES_EQ = 3'b010;
   localparam res_t RES_LT = 3'b001;

endpackage

// File: rtl/mag_cmp_digit.sv
// Combinational unsigned compare of one DIGIT-wide slice; zero latency,
// no flow control.
module mag_cmp_digit #(
   parameter int W = 2
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         gt,
   output logic         eq
);

   assign gt = (a > b);
   assign eq = (a == b);

endmodule

// File: rtl/seq_mag_cmp.sv
// Digit-serial MSB-first magnitude comparator: WIDTH/DIGIT cycles per compare
// (fewer with SEQ_MAG_CMP_EARLY_EXIT_EN); start is ignored while busy.
module seq_mag_cmp
   import cmp_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic             GT,
   output logic             EQ,
   output logic             LT
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = $clog2(NDIG + 1);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sh, b_sh;
   logic [CW-1:0]    cnt;
   res_t             res_q, res_nxt;
   logic             dig_gt, dig_eq;
   logic             accept, last_dig;

   mag_cmp_digit #(.W(DIGIT)) u_digit (
      .a  (a_sh[WIDTH-1 -: DIGIT]),
      .b  (b_sh[WIDTH-1 -: DIGIT]),
      .gt (dig_gt),
      .eq (dig_eq)
   );

   assign accept = start && (state != RUN);

   // Once a digit has differed the verdict is frozen; RES_EQ means "undecided".
   always_comb begin
      res_nxt = res_q;
      if (res_q == RES_EQ && !dig_eq) begin
         res_nxt = dig_gt ? RES_GT : RES_LT;
      end
   end

`ifdef SEQ_MAG_CMP_EARLY_EXIT_EN
   assign last_dig = (cnt == CW'(1)) || (res_nxt != RES_EQ);
`else
   assign last_dig = (cnt == CW'(1));
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (accept) state_nxt = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (last_dig) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = accept ? RUN : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sh         <= '0;
         b_sh         <= '0;
         cnt          <= '0;
         res_q        <= '0;
         {GT, EQ, LT} <= 3'b000;
      end else if (accept) begin
         a_sh  <= A;
         b_sh  <= B;
         cnt   <= CW'(NDIG);
         res_q <= RES_EQ;
      end else if (state == RUN) begin
         a_sh  <= a_sh << DIGIT;
         b_sh  <= b_sh << DIGIT;
         cnt   <= cnt - CW'(1);
         res_q <= res_nxt;
         // Visible result changes only when entering DONE.
         if (last_dig) {GT, EQ, LT} <= res_nxt;
      end
   end

endmodule
